ascon_out_deser: RTL and testbench
==================================

ASCON_OUT_DESER -- requirements
Module: ascon_out_deser

Interface
REQ-001 The block SHALL have parameter BLOCK_BITS, default 128, meaning the number of serial bits captured per stream per run (multiple of 8, 8..128).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, meaning data-byte FIFO entries (power of two, 2..16).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port data_bit_i, input, 1, serial ciphertext/plaintext bit from the cipher core, MSB first.
REQ-006 The block SHALL have port tag_bit_i, input, 1, serial tag bit from the cipher core, MSB first, bit-aligned with data_bit_i.
REQ-007 The block SHALL have port ascon_ready_i, input, 1, the core's ready flag; its rising edge marks the first valid serial bit.
REQ-008 The block SHALL have port out_byte_o, output, 8, the packed byte presented downstream.
REQ-009 The block SHALL have port out_valid_o, output, 1, meaning out_byte_o is valid.
REQ-010 The block SHALL have port out_ready_i, input, 1, downstream accept; transfer occurs when out_valid_o and out_ready_i are both 1.
REQ-011 The block SHALL have port out_is_tag_o, output, 1, meaning the current byte is a tag byte.
REQ-012 The block SHALL have port out_last_o, output, 1, meaning the current byte is the final byte of the run.
REQ-013 The block SHALL have port busy_o, output, 1, high in any state other than IDLE.
REQ-014 The block SHALL have port overflow_o, output, 1, sticky flag: a data byte was dropped.

Function
REQ-015 The FSM SHALL have states IDLE, CAPTURE, TAG_DRAIN.
REQ-016 IDLE -> CAPTURE SHALL occur on the cycle ascon_ready_i is 1 and its registered previous value is 0; that same cycle's data_bit_i/tag_bit_i are bit 0 (MSB).
REQ-017 In CAPTURE the block SHALL sample both streams every cycle for exactly BLOCK_BITS cycles, bit counter 0..BLOCK_BITS-1, then go to TAG_DRAIN.
REQ-018 Every 8th data bit SHALL complete a byte (first bit in out_byte[7]) pushed into the FIFO the following cycle.
REQ-019 If the FIFO is full at push time (no simultaneous pop), the byte SHALL be dropped and overflow_o set to 1 until reset; a simultaneous pop and push on a full FIFO SHALL not overflow.
REQ-020 Tag bits SHALL accumulate in a BLOCK_BITS-bit shift register, no backpressure.
REQ-021 Output priority: FIFO non-empty -> FIFO head, out_is_tag_o=0; else in TAG_DRAIN -> next tag byte MSB-first, out_is_tag_o=1.
REQ-022 out_valid_o SHALL be 0 in IDLE and when the FIFO is empty in CAPTURE.
REQ-023 out_byte_o, out_is_tag_o, out_last_o SHALL be held stable while out_valid_o=1 and out_ready_i=0.
REQ-024 After the transfer with out_last_o=1 the FSM SHALL return to IDLE the next cycle.
REQ-025 Rising edges on ascon_ready_i outside IDLE SHALL be ignored.
REQ-026 Latency: first data byte valid no earlier than 9 cycles after the start edge.

Reset
REQ-027 On rst=1 the block SHALL enter IDLE, empty the FIFO, clear counters, shift registers and edge register, and drive out_byte_o=0, out_valid_o=0, out_is_tag_o=0, out_last_o=0, busy_o=0, overflow_o=0.
REQ-028 Reset mid-run SHALL abandon the run with no further output bytes; a later edge starts a fresh run.

Configuration
REQ-029 With macro ASCON_DESER_TAG_EN defined, tag bytes SHALL follow data bytes and out_last_o SHALL mark the final tag byte (2*BLOCK_BITS/8 bytes per run).
REQ-030 Without ASCON_DESER_TAG_EN, tag_bit_i SHALL be ignored, no tag register exists, out_is_tag_o SHALL be constant 0, TAG_DRAIN SHALL only drain the FIFO, and out_last_o SHALL mark the final data byte (BLOCK_BITS/8 bytes).

Verification
REQ-031 Default params, macro on, out_ready_i=1, data bits 0xA5 repeated, tag 0x0123...CDEF repeated -> 16 bytes 0xA5 (is_tag=0), then 16 tag bytes in order, last only on byte 32, busy_o falls after.
REQ-032 out_ready_i=0 for whole capture -> 4 bytes held, 12 dropped, overflow_o=1; after ready: 4 data bytes then 16 tag bytes.
REQ-033 out_ready_i toggling 1/0 each cycle -> no drops, byte values stable during stalls.
REQ-034 rst asserted at capture bit 50 -> all outputs 0 next cycle; new edge produces a complete correct run.
REQ-035 Second ascon_ready_i edge mid-run -> ignored, run completes unchanged.
REQ-036 Macro off, BLOCK_BITS=64 -> exactly 8 data bytes, last on byte 8, out_is_tag_o never 1.

Source files
------------

// File: rtl/ascon_out_deser.sv
// ascon_out_deser: packs the cipher core's serial data/tag bit streams into
// handshaked bytes. Optional tag path enabled by macro ASCON_DESER_TAG_EN.
// Revision: 1.0
`default_nettype none

module ascon_out_deser #(
  parameter int BLOCK_BITS = 128,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       data_bit_i,
  input  logic       tag_bit_i,
  input  logic       ascon_ready_i,
  output logic [7:0] out_byte_o,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic       out_is_tag_o,
  output logic       out_last_o,
  output logic       busy_o,
  output logic       overflow_o
);

  localparam int NBYTES = BLOCK_BITS / 8;
  localparam int CW     = $clog2(BLOCK_BITS);
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(BLOCK_BITS - 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CAPTURE   = 2'd1,
    TAG_DRAIN = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          ready_prev_q;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0]    data_sr_q, data_sr_d;
  logic          byte_done_q, byte_done_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;

  logic          start, sampling, fifo_empty, fifo_full, fifo_wr, pop;
  logic          tag_avail, last_w, xfer;
  logic [CW-1:0] bit_idx;

`ifdef ASCON_DESER_TAG_EN
  localparam int TCW = $clog2(NBYTES + 1);
  logic [BLOCK_BITS-1:0] tag_sr_q, tag_sr_d;
  logic [TCW-1:0]        tag_cnt_q, tag_cnt_d;
`else
  logic unused_tag_bit;
  assign unused_tag_bit = tag_bit_i;
`endif

  assign start      = (state_q == IDLE) && ascon_ready_i && !ready_prev_q;
  assign sampling   = start || (state_q == CAPTURE);
  assign bit_idx    = start ? '0 : bit_cnt_q;
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);

  // A tag byte may only appear once every data byte, including one still
  // waiting to be pushed, has left the FIFO.
`ifdef ASCON_DESER_TAG_EN
  assign tag_avail = (state_q == TAG_DRAIN) && fifo_empty && !byte_done_q;
  assign last_w    = tag_avail && (tag_cnt_q == TCW'(NBYTES - 1));
`else
  assign tag_avail = 1'b0;
  assign last_w    = (state_q == TAG_DRAIN) && !byte_done_q && (count_q == (AW+1)'(1));
`endif

  assign out_valid_o = (state_q != IDLE) && (!fifo_empty || tag_avail);
  assign xfer        = out_valid_o && out_ready_i;
  assign pop         = xfer && !fifo_empty;
  assign fifo_wr     = byte_done_q && (!fifo_full || pop);

  always_comb begin
    out_byte_o = 8'h00;
    if (state_q != IDLE && !fifo_empty) begin
      out_byte_o = mem_q[rd_ptr_q];
    end
`ifdef ASCON_DESER_TAG_EN
    else if (tag_avail) begin
      out_byte_o = tag_sr_q[BLOCK_BITS-1 -: 8];
    end
`endif
  end

  assign out_is_tag_o = tag_avail;
  assign out_last_o   = out_valid_o && last_w;
  assign busy_o       = (state_q != IDLE);
  assign overflow_o   = overflow_q;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    data_sr_d   = data_sr_q;
    byte_done_d = 1'b0;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
`ifdef ASCON_DESER_TAG_EN
    tag_sr_d    = tag_sr_q;
    tag_cnt_d   = tag_cnt_q;
`endif

    if (sampling) begin
      data_sr_d   = {data_sr_q[6:0], data_bit_i};
      byte_done_d = (bit_idx[2:0] == 3'b111);
      bit_cnt_d   = bit_idx + 1'b1;
`ifdef ASCON_DESER_TAG_EN
      tag_sr_d    = {tag_sr_q[BLOCK_BITS-2:0], tag_bit_i};
`endif
    end

`ifdef ASCON_DESER_TAG_EN
    if (start) begin
      tag_cnt_d = '0;
    end else if (tag_avail && out_ready_i) begin
      tag_sr_d  = tag_sr_q << 8;
      tag_cnt_d = tag_cnt_q + 1'b1;
    end
`endif

    if (fifo_wr) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (fifo_wr && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!fifo_wr && pop) begin
      count_d = count_q - 1'b1;
    end
    if (byte_done_q && fifo_full && !pop) begin
      overflow_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (bit_cnt_q == LAST_BIT) begin
          state_d = TAG_DRAIN;
        end
      end
      TAG_DRAIN: begin
        if (xfer && last_w) begin
          state_d = IDLE;
        end
`ifndef ASCON_DESER_TAG_EN
        // Nothing left to send: every byte was already drained or dropped.
        if (fifo_empty && !byte_done_q) begin
          state_d = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ready_prev_q <= 1'b0;
      bit_cnt_q    <= '0;
      data_sr_q    <= '0;
      byte_done_q  <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
`ifdef ASCON_DESER_TAG_EN
      tag_sr_q     <= '0;
      tag_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ready_prev_q <= ascon_ready_i;
      bit_cnt_q    <= bit_cnt_d;
      data_sr_q    <= data_sr_d;
      byte_done_q  <= byte_done_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
`ifdef ASCON_DESER_TAG_EN
      tag_sr_q     <= tag_sr_d;
      tag_cnt_q    <= tag_cnt_d;
`endif
    end
  end

  // Storage only; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      mem_q[wr_ptr_q] <= data_sr_q;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ascon_out_deser.sv
// tb_ascon_out_deser: scoreboard bench for ascon_out_deser (default parameters);
// expectations follow ASCON_DESER_TAG_EN when it is defined.
`default_nettype none

module tb_ascon_out_deser;

  localparam int BB = 128;
  localparam int NB = BB / 8;
  localparam logic [127:0] TAG = 128'h0123456789ABCDEF0123456789ABCDEF;
`ifdef ASCON_DESER_TAG_EN
  localparam bit TAG_ON = 1'b1;
`else
  localparam bit TAG_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       data_bit_i = 1'b0;
  logic       tag_bit_i = 1'b0;
  logic       ascon_ready_i = 1'b0;
  logic [7:0] out_byte_o;
  logic       out_valid_o;
  logic       out_ready_i;
  logic       out_is_tag_o;
  logic       out_last_o;
  logic       busy_o;
  logic       overflow_o;

  int checks = 0;
  int failures = 0;
  int mode = 0;  // 0: always ready, 1: toggle, 2: never ready
  logic [9:0] exp_q[$];  // {byte, is_tag, last}

  ascon_out_deser dut (
    .clk(clk), .rst(rst), .data_bit_i(data_bit_i), .tag_bit_i(tag_bit_i),
    .ascon_ready_i(ascon_ready_i), .out_byte_o(out_byte_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_is_tag_o(out_is_tag_o), .out_last_o(out_last_o),
    .busy_o(busy_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  initial begin
    out_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0: out_ready_i = 1'b1;
        1: out_ready_i = ~out_ready_i;
        default: out_ready_i = 1'b0;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every transfer, checks hold during stalls.
  initial begin
    logic       prev_stall;
    logic       last_seen;
    logic [10:0] prev;
    logic [9:0] e;
    prev_stall = 1'b0;
    last_seen  = 1'b0;
    prev       = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
        last_seen  = 1'b0;
      end else begin
        if (last_seen) begin
          chk("busy_after_last", {31'd0, busy_o}, 32'd0);
          last_seen = 1'b0;
        end
        if (prev_stall) begin
          chk("hold_during_stall", {21'd0, out_valid_o, out_byte_o, out_is_tag_o, out_last_o},
              {21'd0, prev});
        end
        if (out_valid_o && out_ready_i) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_byte: got %h/%b/%b expected none", out_byte_o,
                     out_is_tag_o, out_last_o);
          end else begin
            e = exp_q.pop_front();
            if ({out_byte_o, out_is_tag_o, out_last_o} !== e) begin
              failures++;
              $display("FAIL out_byte: got %h tag=%b last=%b expected %h tag=%b last=%b",
                       out_byte_o, out_is_tag_o, out_last_o, e[9:2], e[1], e[0]);
            end
          end
          if (out_last_o) last_seen = 1'b1;
        end
        prev_stall = out_valid_o && !out_ready_i;
        prev = {out_valid_o, out_byte_o, out_is_tag_o, out_last_o};
      end
    end
  end

  function automatic logic [7:0] data_byte(input int pat, input int k);
    return (pat == 1) ? 8'(k) : 8'hA5;
  endfunction

  function automatic logic dbit(input int pat, input int i);
    logic [7:0] b;
    b = data_byte(pat, i / 8);
    return b[7 - (i % 8)];
  endfunction

  function automatic logic tbit(input int i);
    logic [127:0] t;
    t = TAG;
    return t[127 - i];
  endfunction

  // Expect the first n_data data bytes, then the full tag when enabled.
  task automatic push_exp(input int pat, input int n_data);
    logic [127:0] t;
    t = TAG;
    for (int k = 0; k < n_data; k++)
      exp_q.push_back({data_byte(pat, k), 1'b0, (!TAG_ON && k == n_data - 1)});
    if (TAG_ON)
      for (int k = 0; k < NB; k++)
        exp_q.push_back({t[127 - 8*k -: 8], 1'b1, (k == NB - 1)});
  endtask

  // Drives one run; the edge cycle carries bit 0. glitch re-raises ready mid-run.
  task automatic run_stim(input int pat, input bit glitch);
    @(posedge clk);
    #1;
    for (int i = 0; i < BB; i++) begin
      ascon_ready_i = (glitch && i >= 20 && i < 30) ? 1'b0 : 1'b1;
      data_bit_i = dbit(pat, i);
      tag_bit_i  = tbit(i);
      @(posedge clk);
      #1;
    end
    ascon_ready_i = 1'b0;
    data_bit_i = 1'b0;
    tag_bit_i  = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((busy_o || exp_q.size() != 0) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, {31'd0, (n >= 3000)}, 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_outputs", {19'd0, out_byte_o, out_valid_o, out_is_tag_o, out_last_o,
                          busy_o, overflow_o}, 32'd0);

    // Full-throughput run.
    mode = 0;
    push_exp(0, NB);
    run_stim(0, 1'b0);
    wait_done("run_ready_timeout");
    chk("no_overflow_ready", {31'd0, overflow_o}, 32'd0);

    // Alternating downstream ready.
    mode = 1;
    push_exp(1, NB);
    run_stim(1, 1'b0);
    wait_done("run_toggle_timeout");
    chk("no_overflow_toggle", {31'd0, overflow_o}, 32'd0);

    // Second rising edge of ascon_ready_i in mid-capture.
    mode = 0;
    push_exp(0, NB);
    run_stim(0, 1'b1);
    wait_done("run_glitch_timeout");

    // Downstream stalled for the whole capture: only the first four survive.
    mode = 2;
    push_exp(1, 4);
    run_stim(1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("overflow_set", {31'd0, overflow_o}, 32'd1);
    chk("held_head", {23'd0, out_valid_o, out_byte_o}, {23'd0, 1'b1, 8'h00});
    mode = 0;
    wait_done("run_overflow_timeout");
    chk("overflow_sticky", {31'd0, overflow_o}, 32'd1);

    // Reset at capture bit 50, then a fresh run.
    mode = 2;
    @(posedge clk);
    #1;
    for (int i = 0; i <= 50; i++) begin
      ascon_ready_i = 1'b1;
      data_bit_i = dbit(0, i);
      tag_bit_i  = tbit(i);
      if (i == 50) begin
        chk("pre_reset_state", {29'd0, out_valid_o, busy_o, overflow_o}, 32'd7);
        rst = 1'b1;
        ascon_ready_i = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    chk("midrun_reset_outputs", {19'd0, out_byte_o, out_valid_o, out_is_tag_o, out_last_o,
                                 busy_o, overflow_o}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("idle_after_reset", {30'd0, busy_o, out_valid_o}, 32'd0);
    mode = 0;
    push_exp(1, NB);
    run_stim(1, 1'b0);
    wait_done("run_after_reset_timeout");
    chk("no_overflow_after_reset", {31'd0, overflow_o}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
